// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// master: drives req_valid, MemRead, MemWrite, addr, wr_data, func3;
//         receives req_ready, rsp_valid, rd_data, access_err.
// slave:  the mirror image, used by the responder.
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            func3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  access_err;

    modport master (
        output req_valid, MemRead, MemWrite, addr, wr_data, func3,
        input  req_ready, rsp_valid, rd_data, access_err
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, addr, wr_data, func3,
        output req_ready, rsp_valid, rd_data, access_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressable data memory with a valid/ready request side and a
// one-cycle response pulse after WAIT_CYCLES wait states.
// Ports: clk, reset (async, active-high), bus (dmem_responder_if.slave):
//   req_valid/req_ready handshake, MemRead/MemWrite/addr/wr_data/func3
//   request fields, rsp_valid pulse with rd_data and access_err.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int         LP_WORDS = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] LP_WLOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_rd;
    logic                  r_wr;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_f3;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_err;
    logic [DATA_W-1:0]     r_mem [LP_WORDS];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_rd;
    logic                  w_wr;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic [2:0]            w_f3;
    logic [1:0]            w_lane;
    logic [DATA_W-1:0]     w_word;
    logic [DATA_W-1:0]     w_rsh;
    logic [DATA_W-1:0]     w_wsh;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_rdata;
    logic                  w_err;

    assign w_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept = bus.req_valid && w_ready;

    // With zero wait states RESP is entered on the accept edge itself,
    // so the decode must look at the live bus rather than the capture.
    assign w_enter_resp =
        (r_state == S_WAIT && r_cnt == 4'd0) ||
        (w_accept && WAIT_CYCLES == 0);

    assign w_rd    = (r_state == S_IDLE) ? bus.MemRead  : r_rd;
    assign w_wr    = (r_state == S_IDLE) ? bus.MemWrite : r_wr;
    assign w_addr  = (r_state == S_IDLE) ? bus.addr     : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? bus.wr_data  : r_wdata;
    assign w_f3    = (r_state == S_IDLE) ? bus.func3    : r_f3;

    assign w_lane = w_addr[1:0];
    assign w_word = r_mem[w_addr[DM_ADDRESS-1:2]];
    assign w_rsh  = w_word >> {w_lane, 3'b000};
    assign w_wsh  = w_wdata << {w_lane, 3'b000};

    // A simultaneous read+write request is handled as a store.
    always_comb begin
        w_be    = 4'b0000;
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_wr) begin
            unique case (w_f3)
                3'b000: w_be = 4'b0001 << w_lane;
                3'b001: begin
                    if (w_lane[0]) w_err = 1'b1;
                    else           w_be  = 4'b0011 << w_lane;
                end
                3'b010: begin
                    if (w_lane != 2'd0) w_err = 1'b1;
                    else                w_be  = 4'b1111;
                end
                default: w_err = 1'b1;
            endcase
        end else if (w_rd) begin
            unique case (w_f3)
                3'b000: w_rdata = {{(DATA_W-8){w_rsh[7]}}, w_rsh[7:0]};
                3'b100: w_rdata = {{(DATA_W-8){1'b0}}, w_rsh[7:0]};
                3'b001, 3'b101: begin
                    if (w_lane[0])
                        w_err = 1'b1;
                    else
                        w_rdata = {{(DATA_W-16){w_rsh[15] & ~w_f3[2]}},
                                   w_rsh[15:0]};
                end
                3'b010: begin
                    if (w_lane != 2'd0) w_err   = 1'b1;
                    else                w_rdata = w_word;
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_addr[DM_ADDRESS-1:2]][8*i +: 8] <= w_wsh[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_f3        <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd    <= bus.MemRead;
                        r_wr    <= bus.MemWrite;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wr_data;
                        r_f3    <= bus.func3;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_WLOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rd_data   <= w_rdata;
                r_err       <= w_err;
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rd_data    = r_rd_data;
    assign bus.access_err = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT with two wait states and
// one with zero wait states for the back-to-back throughput scenario.
module tb_dmem_responder;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus1 ();
    dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus2 ();

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_req(input logic rd, input logic wr,
                          input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f3,
                          output logic [31:0] rdata, output logic err,
                          output int lat);
        int guard;
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.MemRead   = rd;
        bus1.MemWrite  = wr;
        bus1.addr      = a;
        bus1.wr_data   = d;
        bus1.func3     = f3;
        guard = 0;
        while (!bus1.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        bus1.MemRead   = 1'b0;
        bus1.MemWrite  = 1'b0;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus1.rsp_valid) begin
                lat   = k;
                rdata = bus1.rd_data;
                err   = bus1.access_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (bus1.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got=%b exp=0", bus1.req_ready);
        end
        tests++;
        if (bus1.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp_valid got=%b exp=0", bus1.rsp_valid);
        end
        tests++;
        if (bus1.rd_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_rd_data got=%h exp=0", bus1.rd_data);
        end
        tests++;
        if (bus1.access_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err got=%b exp=0", bus1.access_err);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bus1.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_ready got=%b exp=1", bus1.req_ready);
        end
    endtask

    task automatic test_sw_lw;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er, lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL sw_latency got=%0d exp=2", lat);
        end
        tests++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            fails++;
            $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, er);
        end
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL lw_latency got=%0d exp=2", lat);
        end
        tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            fails++;
            $display("FAIL lw_data got=%h/%b exp=deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte_half;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b0, 1'b1, 9'h011, 32'h00000080, 3'b000, rd, er, lat);
        do_req(1'b1, 1'b0, 9'h011, 32'h0, 3'b000, rd, er, lat);
        tests++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            fails++;
            $display("FAIL lb got=%h/%b exp=ffffff80/0", rd, er);
        end
        do_req(1'b1, 1'b0, 9'h011, 32'h0, 3'b100, rd, er, lat);
        tests++;
        if (rd !== 32'h00000080) begin
            fails++;
            $display("FAIL lbu got=%h exp=00000080", rd);
        end
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'hDEAD80EF) begin
            fails++;
            $display("FAIL lw_after_sb got=%h exp=dead80ef", rd);
        end
        do_req(1'b1, 1'b0, 9'h012, 32'h0, 3'b001, rd, er, lat);
        tests++;
        if (rd !== 32'hFFFFDEAD) begin
            fails++;
            $display("FAIL lh got=%h exp=ffffdead", rd);
        end
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b101, rd, er, lat);
        tests++;
        if (rd !== 32'h000080EF) begin
            fails++;
            $display("FAIL lhu got=%h exp=000080ef", rd);
        end
        do_req(1'b0, 1'b1, 9'h042, 32'hABCD1234, 3'b001, rd, er, lat);
        do_req(1'b1, 1'b0, 9'h040, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'h12340000) begin
            fails++;
            $display("FAIL sh_upper got=%h exp=12340000", rd);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 1'b0, 9'h013, 32'h0, 3'b001, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL lh_misaligned got=%h/%b exp=0/1", rd, er);
        end
        do_req(1'b0, 1'b1, 9'h022, 32'hFFFFFFFF, 3'b010, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL sw_misaligned got=%h/%b exp=0/1", rd, er);
        end
        do_req(1'b1, 1'b0, 9'h020, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            fails++;
            $display("FAIL no_write_misaligned got=%h/%b exp=0/0", rd, er);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.MemRead   = 1'b0;
        bus1.MemWrite  = 1'b1;
        bus1.addr      = 9'h030;
        bus1.wr_data   = 32'h12345678;
        bus1.func3     = 3'b010;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        bus1.MemWrite  = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if (bus1.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_ready_in_reset got=%b exp=0", bus1.req_ready);
        end
        seen = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (bus1.req_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_ready_release got=%b exp=1", bus1.req_ready);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_rsp got=%0d exp=0", seen);
        end
        do_req(1'b1, 1'b0, 9'h030, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'h0 || lat !== 2) begin
            fails++;
            $display("FAIL abort_no_commit got=%h lat=%0d exp=0 lat=2", rd, lat);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b011, rd, er, lat);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL load_f3_011 got=%h/%b exp=0/1", rd, er);
        end
        do_req(1'b0, 1'b1, 9'h060, 32'hCAFEF00D, 3'b011, rd, er, lat);
        tests++;
        if (er !== 1'b1) begin
            fails++;
            $display("FAIL store_f3_011 got=%b exp=1", er);
        end
        do_req(1'b1, 1'b0, 9'h060, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'h0) begin
            fails++;
            $display("FAIL illegal_no_write got=%h exp=0", rd);
        end
        do_req(1'b0, 1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            fails++;
            $display("FAIL noop got=%h/%b lat=%0d exp=0/0 lat=2", rd, er, lat);
        end
        do_req(1'b1, 1'b1, 9'h050, 32'h55AA55AA, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            fails++;
            $display("FAIL rdwr_rsp got=%h/%b exp=0/0", rd, er);
        end
        do_req(1'b1, 1'b0, 9'h050, 32'h0, 3'b010, rd, er, lat);
        tests++;
        if (rd !== 32'h55AA55AA) begin
            fails++;
            $display("FAIL rdwr_is_store got=%h exp=55aa55aa", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0]  ad  [4];
        logic [31:0] dt  [4];
        int          acc [4];
        int          rc  [4];
        logic [31:0] rdv [4];
        int          j;
        int          n;
        logic        rdy;
        ad = '{9'h000, 9'h004, 9'h008, 9'h00C};
        dt = '{32'h11111111, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h87654321};
        for (int ph = 0; ph < 2; ph++) begin
            j = 0;
            n = 0;
            for (int k = 0; k < 4; k++) begin
                acc[k] = -1;
                rc[k]  = -1;
                rdv[k] = 32'h0;
            end
            @(negedge clk);
            bus2.req_valid = 1'b1;
            bus2.MemRead   = (ph == 1);
            bus2.MemWrite  = (ph == 0);
            bus2.func3     = 3'b010;
            bus2.addr      = ad[0];
            bus2.wr_data   = dt[0];
            for (int c = 0; c < 16; c++) begin
                rdy = bus2.req_ready;
                @(posedge clk);
                if (rdy && j < 4) begin
                    acc[j] = c;
                    j++;
                end
                @(negedge clk);
                if (bus2.rsp_valid && n < 4) begin
                    rc[n]  = c;
                    rdv[n] = bus2.rd_data;
                    n++;
                end
                if (j < 4) begin
                    bus2.addr    = ad[j];
                    bus2.wr_data = dt[j];
                end else begin
                    bus2.req_valid = 1'b0;
                    bus2.MemRead   = 1'b0;
                    bus2.MemWrite  = 1'b0;
                end
            end
            tests++;
            if (n !== 4) begin
                fails++;
                $display("FAIL b2b_rsp_count ph=%0d got=%0d exp=4", ph, n);
            end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (acc[k] !== 2 * k) begin
                    fails++;
                    $display("FAIL b2b_accept ph=%0d k=%0d got=%0d exp=%0d",
                             ph, k, acc[k], 2 * k);
                end
                tests++;
                if (rc[k] !== 2 * k) begin
                    fails++;
                    $display("FAIL b2b_rsp ph=%0d k=%0d got=%0d exp=%0d",
                             ph, k, rc[k], 2 * k);
                end
                if (ph == 1) begin
                    tests++;
                    if (rdv[k] !== dt[k]) begin
                        fails++;
                        $display("FAIL b2b_data k=%0d got=%h exp=%h",
                                 k, rdv[k], dt[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset          = 1'b1;
        bus1.req_valid = 1'b0;
        bus1.MemRead   = 1'b0;
        bus1.MemWrite  = 1'b0;
        bus1.addr      = '0;
        bus1.wr_data   = '0;
        bus1.func3     = 3'b000;
        bus2.req_valid = 1'b0;
        bus2.MemRead   = 1'b0;
        bus2.MemWrite  = 1'b0;
        bus2.addr      = '0;
        bus2.wr_data   = '0;
        bus2.func3     = 3'b000;
        test_reset;
        test_sw_lw;
        test_byte_half;
        test_misaligned;
        test_reset_abort;
        test_illegal;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, byte-address width; storage is 2^DM_ADDRESS bytes, organised as 128 x 32-bit words.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter WAIT_CYCLES, default 2, legal range 0..15; number of wait states inserted before each response.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  1  initiator presents a request.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 MemRead  input  1  request is a load.
REQ-010 MemWrite  input  1  request is a store.
REQ-011 addr  input  DM_ADDRESS  byte address, little-endian.
REQ-012 wr_data  input  DATA_W  store data, right-aligned.
REQ-013 func3  input  3  access size/sign code, RV32I encoding.
REQ-014 rsp_valid  output  1  one-cycle pulse marking a completed request.
REQ-015 rd_data  output  DATA_W  load result; valid only while rsp_valid=1.
REQ-016 access_err  output  1  valid with rsp_valid; marks a misaligned or illegal access.

Function
REQ-017 FSM states are IDLE, WAIT and RESP; req_ready shall be 1 only in IDLE with reset low.
REQ-018 Handshake: a request is accepted at a rising edge where req_valid=1 and req_ready=1; MemRead, MemWrite, addr, wr_data and func3 are captured at that edge.
REQ-019 Transitions: IDLE goes to WAIT on accept with WAIT_CYCLES>0, or directly to RESP with WAIT_CYCLES=0.
REQ-020 WAIT holds a counter loaded with WAIT_CYCLES-1 and decrements it each cycle; WAIT goes to RESP when the counter reaches 0.
REQ-021 RESP lasts exactly one cycle, then returns to IDLE.
REQ-022 Latency: rsp_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge, for one cycle; peak throughput is one request per WAIT_CYCLES+2 cycles.
REQ-023 Addressing: word index = addr[DM_ADDRESS-1:2]; byte lane = addr[1:0]; byte 0 is bits [7:0].
REQ-024 Loads, selected by func3: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-025 Stores, selected by func3: 000 SB, 001 SH, 010 SW; only the addressed bytes are modified.
REQ-026 Store commit: the memory write occurs on the edge entering RESP; a load issued after the store's response observes the new data.
REQ-027 Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0, gives access_err=1, no memory write and rd_data=0.
REQ-028 Illegal func3: any code not listed above for the access type gives access_err=1, no write and rd_data=0.
REQ-029 MemRead=1 and MemWrite=1 together: treat as a store; rd_data=0.
REQ-030 MemRead=0 and MemWrite=0: no-op; still responds with rsp_valid=1, rd_data=0, access_err=0.
REQ-031 rd_data and access_err shall be 0 whenever rsp_valid=0.
REQ-032 req_valid while req_ready=0 is ignored; the initiator must hold the request until it is accepted.

Reset
REQ-033 Reset shall immediately force state IDLE, counter 0, rsp_valid=0, rd_data=0, access_err=0 and req_ready=0.
REQ-034 Reset asserted in WAIT or RESP abandons the request; a pending store is not committed and no response is issued.
REQ-035 Memory contents are not cleared by reset; all words are zero at time 0.
REQ-036 After reset deasserts, req_ready=1 in the first cycle.

Verification
REQ-037 WAIT_CYCLES=2: SW addr=0x010, wr_data=0xDEADBEEF, then LW addr=0x010 -> each rsp_valid exactly 3 cycles after its accept edge; load returns rd_data=0xDEADBEEF, access_err=0.
REQ-038 After REQ-037: SB addr=0x011, wr_data=0x80; then LB 0x011 -> 0xFFFFFF80; LBU 0x011 -> 0x00000080; LW 0x010 -> 0xDEAD80EF.
REQ-039 LH addr=0x013 and SW addr=0x022 -> access_err=1, rd_data=0; a following LW 0x020 shows the word unchanged.
REQ-040 Reset pulse during WAIT of SW addr=0x030, wr_data=0x12345678 -> no rsp_valid; req_ready=1 in the first cycle after release; LW 0x030 -> 0x00000000.
REQ-041 WAIT_CYCLES=0 with req_valid held high over 4 back-to-back loads -> accept every 2nd cycle; rsp_valid pulses on alternate cycles.
REQ-042 func3=011 with MemRead=1 -> access_err=1; MemRead=MemWrite=0 -> rsp_valid=1, rd_data=0, access_err=0.
